// File: rtl/ah_addr_range_decoder_pkg.sv
// ah_dec_pkg: shared widths, window-entry type and priority encoder for the address-range decoder.
package ah_dec_pkg;

    localparam int AH_ADDR_W      = 24;
    localparam int AH_NUM_CLIENTS = 12;
    localparam int AH_ERR_CNT_W   = 16;

    typedef struct packed {
        logic                 en;
        logic [AH_ADDR_W-1:0] base;
        logic [AH_ADDR_W-1:0] limit;
    } ah_range_entry_t;

    function automatic logic [4:0] ah_prio_enc(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) if (v[i]) r = 5'(i);
        return r;
    endfunction

endpackage

// File: rtl/ah_addr_range_decoder_if.sv
// ah_addr_range_decoder_if: config, ingress, result and status signals of the address-range decoder.
interface ah_addr_range_decoder_if
    import ah_dec_pkg::*;
#(
    parameter int ADDR_W      = AH_ADDR_W,
    parameter int NUM_CLIENTS = AH_NUM_CLIENTS,
    parameter int ERR_CNT_W   = AH_ERR_CNT_W
);
    localparam int IDX_W = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;

    logic                   cfg_wr;
    logic [IDX_W-1:0]       cfg_idx;
    logic [ADDR_W-1:0]      cfg_base;
    logic [ADDR_W-1:0]      cfg_limit;
    logic                   cfg_en;
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDR_W-1:0]      in_addr;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_CLIENTS-1:0] out_hit_vec;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_multi;
    logic                   out_err;
    logic                   err_clr;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output cfg_wr, cfg_idx, cfg_base, cfg_limit, cfg_en, in_valid, in_addr, out_ready, err_clr,
        input  in_ready, out_valid, out_hit_vec, out_idx, out_multi, out_err, err_cnt
    );

    modport slave (
        input  cfg_wr, cfg_idx, cfg_base, cfg_limit, cfg_en, in_valid, in_addr, out_ready, err_clr,
        output in_ready, out_valid, out_hit_vec, out_idx, out_multi, out_err, err_cnt
    );

endinterface

// File: rtl/ah_addr_range_decoder_range_cmp.sv
// ah_range_cmp: single inclusive [base,limit] window match; an inverted window never matches.
module ah_range_cmp
    import ah_dec_pkg::*;
(
    input  ah_range_entry_t      entry_i,
    input  logic [AH_ADDR_W-1:0] addr_i,
    output logic                 hit_o
);

    assign hit_o = entry_i.en && (entry_i.base <= addr_i) && (addr_i <= entry_i.limit);

endmodule

// File: rtl/ah_addr_range_decoder.sv
// ah_addr_range_decoder: programmable window table, registered decode stage and saturating error counter.
module ah_addr_range_decoder
    import ah_dec_pkg::*;
#(
    parameter int NUM_CLIENTS = AH_NUM_CLIENTS,
    parameter int ERR_CNT_W   = AH_ERR_CNT_W
)(
    input logic                    clk,
    input logic                    rst,
    ah_addr_range_decoder_if.slave dec_if
);

    localparam int IDX_W = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
    localparam ah_range_entry_t RST_ENTRY = '{1'b0, {AH_ADDR_W{1'b1}}, {AH_ADDR_W{1'b0}}};

    ah_range_entry_t        tbl_q [NUM_CLIENTS];
    ah_range_entry_t        tbl_d [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] hit;
    logic [NUM_CLIENTS-1:0] hit_q, hit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   multi_q, multi_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   accept;
    logic                   xfer;

    for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_cmp
        ah_range_cmp u_cmp (
            .entry_i (tbl_q[c]),
            .addr_i  (dec_if.in_addr),
            .hit_o   (hit[c])
        );
    end

    assign dec_if.in_ready = ~valid_q | dec_if.out_ready;
    assign accept          = dec_if.in_valid & dec_if.in_ready;
    assign xfer            = valid_q & dec_if.out_ready;

    // Table writes land at the clock edge, so an input accepted alongside a write sees the old entry.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++)
            tbl_d[i] = (dec_if.cfg_wr && dec_if.cfg_idx == IDX_W'(i))
                     ? ah_range_entry_t'({dec_if.cfg_en, dec_if.cfg_base, dec_if.cfg_limit})
                     : tbl_q[i];
        valid_d = accept | (valid_q & ~dec_if.out_ready);
        hit_d   = accept ? hit : hit_q;
        idx_d   = accept ? IDX_W'(ah_prio_enc(32'(hit))) : idx_q;
        multi_d = accept ? |(hit & (hit - NUM_CLIENTS'(1))) : multi_q;
        err_d   = accept ? ~|hit : err_q;
        cnt_d   = dec_if.err_clr ? '0
                : (xfer && err_q && ~&cnt_q) ? cnt_q + ERR_CNT_W'(1)
                : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLIENTS; i++) tbl_q[i] <= RST_ENTRY;
            valid_q <= 1'b0;
            hit_q   <= '0;
            idx_q   <= '0;
            multi_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            tbl_q   <= tbl_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dec_if.out_valid   = valid_q;
    assign dec_if.out_hit_vec = hit_q;
    assign dec_if.out_idx     = idx_q;
    assign dec_if.out_multi   = multi_q;
    assign dec_if.out_err     = err_q;
    assign dec_if.err_cnt     = cnt_q;

endmodule
